// File: rtl/synth_pkg.sv
// Shared types and constants for the voice allocator and its voice slots.
// Optional feature macro: VOICE_STEAL_EN (enables oldest-voice stealing and age counters).
package synth_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } alloc_state_t;

    localparam int MIDI_NOTE_W   = 7;
    localparam int MIDI_VEL_W    = 7;
    localparam int AGE_W_DEFAULT = 4;

    // Saturation value of an age counter of the given width.
    function automatic int age_max_f(input int age_w);
        return (1 << age_w) - 1;
    endfunction

    localparam int AGE_MAX = age_max_f(AGE_W_DEFAULT);

endpackage

// File: rtl/voice_slot.sv
// One voice of the allocator: note, volume, active flag and (with VOICE_STEAL_EN)
// a saturating age counter. Load assigns a note; release silences but keeps the note.
module voice_slot
    import synth_pkg::*;
#(
    parameter int AGE_W = AGE_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_load,
    input  logic [MIDI_NOTE_W-1:0] i_note,
    input  logic [MIDI_VEL_W-1:0]  i_vol,
    input  logic                   i_release,
`ifdef VOICE_STEAL_EN
    input  logic                   i_age_inc,
    output logic [AGE_W-1:0]       o_age,
`endif
    output logic [MIDI_NOTE_W-1:0] o_note,
    output logic [MIDI_VEL_W-1:0]  o_vol,
    output logic                   o_active
);

    logic [MIDI_NOTE_W-1:0] r_note;
    logic [MIDI_VEL_W-1:0]  r_vol;
    logic                   r_active;

    // Note/volume/active registers: load wins over release.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_note   <= '0;
            r_vol    <= '0;
            r_active <= 1'b0;
        end else if (i_load) begin
            r_note   <= i_note;
            r_vol    <= i_vol;
            r_active <= 1'b1;
        end else if (i_release) begin
            r_vol    <= '0;
            r_active <= 1'b0;
        end
    end

    assign o_note   = r_note;
    assign o_vol    = r_vol;
    assign o_active = r_active;

`ifdef VOICE_STEAL_EN
    localparam logic [AGE_W-1:0] LP_AGE_MAX = AGE_W'(age_max_f(AGE_W));

    logic [AGE_W-1:0] r_age;

    // Age clears on load and saturates while the voice keeps sounding.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_age <= LP_AGE_MAX;
        end else if (i_load) begin
            r_age <= '0;
        end else if (i_age_inc && r_active && (r_age != LP_AGE_MAX)) begin
            r_age <= r_age + 1'b1;
        end
    end

    assign o_age = r_age;
`else
    localparam int unused_age_w = AGE_W;
`endif

endmodule

// File: rtl/voice_allocator.sv
// Polyphony controller: accepts MIDI note events (valid/ready), scans the voices
// one per cycle, then commits an allocation, retrigger or release.
// Optional feature macro: VOICE_STEAL_EN (steal the oldest voice when none is free).
//
// Handshake: an event transfers on a rising edge where ev_valid && ev_ready;
// ev_ready is high only in IDLE, and inputs are ignored at every other edge.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              ev_valid,
    output logic                              ev_ready,
    input  logic                              ev_note_on,
    input  logic [MIDI_NOTE_W-1:0]            ev_note,
    input  logic [MIDI_VEL_W-1:0]             ev_velocity,
    output logic [MIDI_NOTE_W*NUM_VOICES-1:0] voice_note,
    output logic [MIDI_VEL_W*NUM_VOICES-1:0]  voice_volume,
    output logic [NUM_VOICES-1:0]             voice_active,
    output logic [NUM_VOICES-1:0]             voice_retrig,
    output alloc_state_t                      dbg_state
);

    localparam int               IDX_W    = $clog2(NUM_VOICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    alloc_state_t           r_state;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_on;
    logic [MIDI_NOTE_W-1:0] r_note;
    logic [MIDI_VEL_W-1:0]  r_vel;
    logic                   r_match_found;
    logic [IDX_W-1:0]       r_match_idx;
    logic                   r_free_found;
    logic [IDX_W-1:0]       r_free_idx;
    logic [NUM_VOICES-1:0]  r_retrig;

    logic [MIDI_NOTE_W-1:0] w_note [NUM_VOICES];
    logic [NUM_VOICES-1:0]  w_active;
    logic                   w_do_load;
    logic                   w_do_rel;
    logic [IDX_W-1:0]       w_sel;
    logic                   w_accept;

`ifdef VOICE_STEAL_EN
    logic [AGE_W-1:0]       w_age [NUM_VOICES];
    logic                   r_old_found;
    logic [IDX_W-1:0]       r_old_idx;
    logic [AGE_W-1:0]       r_old_age;
`endif

    assign ev_ready  = (r_state == IDLE);
    assign w_accept  = ev_valid && ev_ready;
    assign dbg_state = r_state;

    // Main FSM: latch the event in IDLE, walk the voices, commit for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_on    <= 1'b0;
            r_note  <= '0;
            r_vel   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        // Note-on with zero velocity is a note-off.
                        r_on    <= ev_note_on && (ev_velocity != '0);
                        r_note  <= ev_note;
                        r_vel   <= ev_velocity;
                        r_idx   <= '0;
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    if (r_idx == LAST_IDX) begin
                        r_state <= COMMIT;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                COMMIT:  r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Scan trackers: first matching active voice, first free voice, oldest active voice.
    always_ff @(posedge clk) begin
        if (reset || w_accept) begin
            r_match_found <= 1'b0;
            r_match_idx   <= '0;
            r_free_found  <= 1'b0;
            r_free_idx    <= '0;
`ifdef VOICE_STEAL_EN
            r_old_found   <= 1'b0;
            r_old_idx     <= '0;
            r_old_age     <= '0;
`endif
        end else if (r_state == SCAN) begin
            if (w_active[r_idx] && (w_note[r_idx] == r_note) && !r_match_found) begin
                r_match_found <= 1'b1;
                r_match_idx   <= r_idx;
            end
            if (!w_active[r_idx] && !r_free_found) begin
                r_free_found <= 1'b1;
                r_free_idx   <= r_idx;
            end
`ifdef VOICE_STEAL_EN
            if (w_active[r_idx] && (!r_old_found || (w_age[r_idx] > r_old_age))) begin
                r_old_found <= 1'b1;
                r_old_idx   <= r_idx;
                r_old_age   <= w_age[r_idx];
            end
`endif
        end
    end

    // Commit decision: which voice (if any) is loaded or released this cycle.
    always_comb begin
        w_do_load = 1'b0;
        w_do_rel  = 1'b0;
        w_sel     = r_match_idx;
        if (r_state == COMMIT) begin
            if (r_on) begin
                if (r_match_found) begin
                    w_do_load = 1'b1;
                    w_sel     = r_match_idx;
                end else if (r_free_found) begin
                    w_do_load = 1'b1;
                    w_sel     = r_free_idx;
                end
`ifdef VOICE_STEAL_EN
                else if (r_old_found) begin
                    w_do_load = 1'b1;
                    w_sel     = r_old_idx;
                end
`endif
            end else if (r_match_found) begin
                w_do_rel = 1'b1;
                w_sel    = r_match_idx;
            end
        end
    end

    // Retrigger pulse: set for the assigned voice on the edge leaving COMMIT only.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_retrig <= '0;
        end else if (w_do_load) begin
            r_retrig <= NUM_VOICES'(1) << w_sel;
        end else begin
            r_retrig <= '0;
        end
    end

    assign voice_retrig = r_retrig;

    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
        logic w_hit;
        assign w_hit = (w_sel == IDX_W'(gi));

        voice_slot #(
            .AGE_W(AGE_W)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .i_load    (w_do_load && w_hit),
            .i_note    (r_note),
            .i_vol     (r_vel),
            .i_release (w_do_rel && w_hit),
`ifdef VOICE_STEAL_EN
            .i_age_inc (w_do_load && !w_hit),
            .o_age     (w_age[gi]),
`endif
            .o_note    (w_note[gi]),
            .o_vol     (voice_volume[gi*MIDI_VEL_W +: MIDI_VEL_W]),
            .o_active  (w_active[gi])
        );

        assign voice_note[gi*MIDI_NOTE_W +: MIDI_NOTE_W] = w_note[gi];
    end

    assign voice_active = w_active;

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphony controller that feeds a bank of NUM_VOICES triangle_wave_generator instances.
- Accepts MIDI note events over a valid/ready handshake and assigns each note-on to a voice.
- Drives each voice's MIDI_freq (note number) and volume, plus a one-cycle retrigger pulse ORed into that generator's reset.
- Releases voices on note-off.

Parameters:
- NUM_VOICES, 4: number of generator voices managed (2..16).
- AGE_W, 4: width of per-voice saturating age counter used for stealing.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ev_valid  in  1  event present.
- ev_ready  out  1  allocator can accept an event.
- ev_note_on  in  1  1 = note-on, 0 = note-off.
- ev_note  in  7  MIDI note number 0..127.
- ev_velocity  in  7  MIDI velocity 0..127.
- voice_note  out  7*NUM_VOICES  per-voice note, voice i at bits [7i+6:7i].
- voice_volume  out  7*NUM_VOICES  per-voice volume; 0 when voice idle.
- voice_active  out  NUM_VOICES  voice holds a sounding note.
- voice_retrig  out  NUM_VOICES  one-cycle pulse restarting voice i's generator.

Behaviour:
- Single clock clk; reset is synchronous and active-high.
- Reset state:
  - state IDLE, ev_ready=1.
  - All voice_note=0, voice_volume=0, voice_active=0, voice_retrig=0.
  - All ages = max (2^AGE_W-1).
- FSM states: IDLE, SCAN, COMMIT.
- IDLE:
  - ev_ready=1. On ev_valid&&ev_ready, latch note, velocity and type, then go to SCAN with scan index 0.
  - Note-on with velocity 0 is latched as note-off (MIDI convention).
- SCAN:
  - ev_ready=0. One voice examined per cycle, index 0..NUM_VOICES-1, so NUM_VOICES cycles.
  - Tracks, lowest index winning ties:
    - match = active voice with the same note.
    - free = first inactive voice.
    - oldest = active voice with maximum age.
  - After the last index, go to COMMIT.
- COMMIT (one cycle), then IDLE. Register updates land at the cycle edge leaving COMMIT.
  - Note-on with match: that voice gets volume=velocity, retrig pulse, age=0.
  - Note-on with no match but free: free voice gets note, volume=velocity, active=1, retrig, age=0.
  - Note-on with no match and no free: per Optional Feature.
  - Note-off with match: that voice gets active=0, volume=0; note field retained.
  - Note-off with no match: no change.
- Ageing: on every committed note-on allocation, every other active voice's age increments, saturating at 2^AGE_W-1.
- voice_retrig is high exactly one cycle, the first cycle in IDLE after COMMIT, for exactly the assigned voice; it is 0 in every other cycle.
- Throughput: one event per NUM_VOICES+2 cycles. Outputs reflect an event NUM_VOICES+2 cycles after the accepting edge.
- Reset asserted mid-SCAN or mid-COMMIT aborts the event; the block returns to the reset state with no retrig pulse.
- ev_valid deasserted without handshake is legal and has no effect. Inputs are not sampled outside the IDLE handshake.

Optional Feature:
- Macro: VOICE_STEAL_EN.
- Defined: a note-on with no match and no free voice steals the oldest voice (note, volume, retrig, age=0).
- Undefined: such a note-on is dropped with no output change, and age counters are not instantiated.

Decomposition:
- Package synth_pkg holds:
  - alloc_state_t enum {IDLE, SCAN, COMMIT}.
  - MIDI_NOTE_W=7, MIDI_VEL_W=7.
  - Helper constant AGE_MAX derived from AGE_W.
- Sub-module voice_slot (one per voice) holds note, volume, active and age registers with load/release/age-increment controls.
- voice_allocator holds the FSM, scan logic and handshake.

Test Plan:
- After reset, on(60, vel 100) -> voice0 note=60, vol=100, active=1. retrig[0] pulses 1 cycle, 6 cycles after accept (NUM_VOICES=4). ev_ready low for cycles 1..5.
- on(60,100), on(64,80), on(67,90) -> voices 0,1,2 hold 60/64/67. Then off(64) -> voice1 active=0, vol=0; others unchanged.
- on(60,100), then on(60,50) -> voice0 vol=50, retrig[0] pulses again; no other voice allocated.
- Four note-ons 60,62,64,65, then on(67,70):
  - VOICE_STEAL_EN defined -> voice0 (oldest) gets note=67, vol=70, retrig[0].
  - Undefined -> all outputs unchanged, no retrig.
- on(72, vel 0) after on(72,100) -> treated as note-off: voice0 released. off(50) with no match -> no change.
- Assert reset 2 cycles into SCAN of on(60,100) -> all outputs zero, no retrig. ev_ready=1 the cycle after reset deasserts.
